// File: rtl/div_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// div_ctrl_pkg
// Shared definitions for the iterative MIPS DIV/DIVU controller.
//   DIV_WIDTH   : operand width; also the number of restoring iterations.
//   DIV_CNT_W   : width of the iteration counter (counts 0..DIV_WIDTH).
//   div_state_e : controller state encoding (IDLE / BUSY / DONE).
//   neg_if()    : conditional two's-complement negation used for the
//                 operand magnitudes and the result sign fix-up.
// -----------------------------------------------------------------------------
package div_ctrl_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } div_state_e;

  // Two's-complement negate when en is set, pass through otherwise.
  function automatic logic [DIV_WIDTH-1:0] neg_if(input logic [DIV_WIDTH-1:0] v,
                                                  input logic                 en);
    logic [DIV_WIDTH-1:0] r;
    if (en) begin
      r = ~v + DIV_WIDTH'(1);
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// -----------------------------------------------------------------------------
// div_ctrl_if
// EX-stage <-> divider handshake bundle.
//   start_i   : DIV/DIVU present in EX (held while EX is stalled)
//   signed_i  : 1 = DIV, 0 = DIVU
//   opdata1_i : dividend
//   opdata2_i : divisor
//   annul_i   : exception flush, cancels pending/running division
//   result_o  : {remainder, quotient}, valid while ready_o is high
//   ready_o   : result valid
//   stall_o   : stall request to the hazard unit
// Modports: master = EX stage (drives request), slave = divider.
// -----------------------------------------------------------------------------
interface div_ctrl_if #(
  parameter int WIDTH = div_ctrl_pkg::DIV_WIDTH
);

  logic               start_i;
  logic               signed_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               stall_o;

  modport master (
    output start_i, signed_i, opdata1_i, opdata2_i, annul_i,
    input  result_o, ready_o, stall_o
  );

  modport slave (
    input  start_i, signed_i, opdata1_i, opdata2_i, annul_i,
    output result_o, ready_o, stall_o
  );

endinterface

// File: rtl/div_ctrl_step.sv
// -----------------------------------------------------------------------------
// div_step
// One purely combinational restoring-division iteration.
//   rem_i     : current partial remainder (always < divisor)
//   bit_i     : next dividend bit shifted into the remainder
//   divisor_i : divisor magnitude
//   rem_o     : next partial remainder
//   quo_bit_o : quotient bit produced by this iteration
// -----------------------------------------------------------------------------
module div_step
  import div_ctrl_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] rem_i,
  input  logic                 bit_i,
  input  logic [DIV_WIDTH-1:0] divisor_i,
  output logic [DIV_WIDTH-1:0] rem_o,
  output logic                 quo_bit_o
);

  // The shifted remainder can reach 2*divisor-1, so compare on WIDTH+1 bits.
  logic [DIV_WIDTH:0] shifted_s;
  logic [DIV_WIDTH:0] diff_s;

  // Trial subtraction; restore (keep the shifted value) when it would go negative.
  always_comb begin
    shifted_s = {rem_i, bit_i};
    diff_s    = shifted_s - {1'b0, divisor_i};
    if (shifted_s >= {1'b0, divisor_i}) begin
      rem_o     = diff_s[DIV_WIDTH-1:0];
      quo_bit_o = 1'b1;
    end else begin
      rem_o     = shifted_s[DIV_WIDTH-1:0];
      quo_bit_o = 1'b0;
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl
// Iterative DIV/DIVU controller for the MIPS EX stage. Accepts a request in
// IDLE, runs DIV_WIDTH restoring steps in BUSY (stalling the pipeline), then
// presents {HI = remainder, LO = quotient} in DONE until start_i drops.
// Ports:
//   clk    : pipeline clock
//   resetn : asynchronous active-low reset
//   bus    : div_ctrl_if.slave handshake (request, flush, result, stall)
// Build option:
//   DIV_ZERO_FAST_EN : when defined, a zero divisor seen in IDLE jumps straight
//                      to DONE (ready one cycle after acceptance). Otherwise a
//                      zero divisor runs the full iteration count. Result
//                      values are the same either way.
// -----------------------------------------------------------------------------
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  div_ctrl_if.slave    bus
);

  localparam int WIDTH = DIV_WIDTH;

  div_state_e           state_q,        state_d;
  logic [DIV_CNT_W-1:0] cnt_q,          cnt_d;
  logic [WIDTH-1:0]     rem_q,          rem_d;          // partial remainder
  logic [WIDTH-1:0]     quo_q,          quo_d;          // dividend out / quotient in
  logic [WIDTH-1:0]     divisor_q,      divisor_d;
  logic [WIDTH-1:0]     dividend_raw_q, dividend_raw_d; // unmodified op1 for div-by-zero
  logic                 neg_quo_q,      neg_quo_d;
  logic                 neg_rem_q,      neg_rem_d;
  logic                 div_zero_q,     div_zero_d;
  logic [2*WIDTH-1:0]   result_q,       result_d;
  logic                 ready_q,        ready_d;

  logic                 accept_s;
  logic                 op1_neg_s;
  logic                 op2_neg_s;
  logic [WIDTH-1:0]     step_rem_s;
  logic                 step_bit_s;
  logic [WIDTH-1:0]     quo_next_s;

  // Single restoring iteration on the current partial remainder.
  div_step u_step (
    .rem_i     (rem_q),
    .bit_i     (quo_q[WIDTH-1]),
    .divisor_i (divisor_q),
    .rem_o     (step_rem_s),
    .quo_bit_o (step_bit_s)
  );

  // Request qualification and operand sign decode.
  always_comb begin
    accept_s   = bus.start_i & ~bus.annul_i;
    op1_neg_s  = bus.signed_i & bus.opdata1_i[WIDTH-1];
    op2_neg_s  = bus.signed_i & bus.opdata2_i[WIDTH-1];
    quo_next_s = {quo_q[WIDTH-2:0], step_bit_s};
  end

  // Next-state, datapath and result computation.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rem_d          = rem_q;
    quo_d          = quo_q;
    divisor_d      = divisor_q;
    dividend_raw_d = dividend_raw_q;
    neg_quo_d      = neg_quo_q;
    neg_rem_d      = neg_rem_q;
    div_zero_d     = div_zero_q;
    result_d       = result_q;
    ready_d        = ready_q;

    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b0;
        if (accept_s) begin
          cnt_d          = '0;
          rem_d          = '0;
          quo_d          = neg_if(bus.opdata1_i, op1_neg_s);
          divisor_d      = neg_if(bus.opdata2_i, op2_neg_s);
          dividend_raw_d = bus.opdata1_i;
          neg_quo_d      = op1_neg_s ^ op2_neg_s;
          neg_rem_d      = op1_neg_s;
          div_zero_d     = (bus.opdata2_i == '0);
`ifdef DIV_ZERO_FAST_EN
          if (bus.opdata2_i == '0) begin
            // Result is known up front; skip the iterations entirely.
            state_d  = ST_DONE;
            result_d = {bus.opdata1_i, {WIDTH{1'b1}}};
            ready_d  = 1'b1;
          end else begin
            state_d  = ST_BUSY;
          end
`else
          state_d = ST_BUSY;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_BUSY: begin
        rem_d = step_rem_s;
        quo_d = quo_next_s;
        cnt_d = cnt_q + DIV_CNT_W'(1);
        if (cnt_q == DIV_CNT_W'(WIDTH - 1)) begin
          // Last step: register the sign-corrected result on DONE entry.
          state_d = ST_DONE;
          ready_d = 1'b1;
          if (div_zero_q) begin
            result_d = {dividend_raw_q, {WIDTH{1'b1}}};
          end else begin
            result_d = {neg_if(step_rem_s, neg_rem_q), neg_if(quo_next_s, neg_quo_q)};
          end
        end else begin
          state_d = ST_BUSY;
        end
      end

      ST_DONE: begin
        // Hold the result while EX keeps start_i high; release on first low.
        if (bus.start_i) begin
          state_d = ST_DONE;
          ready_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
          ready_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b0;
      end
    endcase

    // A flush overrides everything and abandons the operation.
    if (bus.annul_i) begin
      state_d = ST_IDLE;
      ready_d = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  // All controller and datapath state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      rem_q          <= '0;
      quo_q          <= '0;
      divisor_q      <= '0;
      dividend_raw_q <= '0;
      neg_quo_q      <= 1'b0;
      neg_rem_q      <= 1'b0;
      div_zero_q     <= 1'b0;
      result_q       <= '0;
      ready_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rem_q          <= rem_d;
      quo_q          <= quo_d;
      divisor_q      <= divisor_d;
      dividend_raw_q <= dividend_raw_d;
      neg_quo_q      <= neg_quo_d;
      neg_rem_q      <= neg_rem_d;
      div_zero_q     <= div_zero_d;
      result_q       <= result_d;
      ready_q        <= ready_d;
    end
  end

  // Outputs: ready/stall drop in the same cycle as a flush, and stall is
  // forced low while reset is held even if EX still presents start_i.
  always_comb begin
    bus.result_o = result_q;
    bus.ready_o  = ready_q & ~bus.annul_i;
    bus.stall_o  = resetn & ~bus.annul_i &
                   (((state_q == ST_IDLE) & bus.start_i) | (state_q == ST_BUSY));
  end

endmodule

// File: tb/tb_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_ctrl
// Scoreboarded bench for div_ctrl: the stimulus process pushes the expected
// {remainder, quotient} for every accepted request; a monitor pops and
// compares on each rising edge of ready_o. Latency, stall and flush/reset
// behaviour are checked from the stimulus side.
// -----------------------------------------------------------------------------
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  localparam int W = DIV_WIDTH;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  always #5 clk = ~clk;

  div_ctrl_if #(.WIDTH(W)) bus ();

  div_ctrl dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] mon_exp;
  bit             prev_ready = 1'b0;

  // Reference: plain language division with MIPS truncation semantics.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input bit s);
    logic [W-1:0] q;
    logic [W-1:0] r;
    if (b == '0) return {a, {W{1'b1}}};
    if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic int exp_latency(input logic [W-1:0] b);
`ifdef DIV_ZERO_FAST_EN
    return (b == '0) ? 1 : W + 1;
`else
    return W + 1;
`endif
  endfunction

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: one scoreboard pop per result presentation.
  always @(negedge clk) begin
    if (!resetn) begin
      prev_ready = 1'b0;
    end else begin
      if (bus.ready_o && !prev_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready actual=%h required=no_result", bus.result_o);
        end else begin
          mon_exp = exp_q.pop_front();
          check("result", bus.result_o, mon_exp);
        end
      end
      prev_ready = bus.ready_o;
    end
  end

  // Issue one request, wait for ready, hold start for 'hold' extra cycles, drop start.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit s, input int hold);
    int lat;
    @(posedge clk); #1;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    bus.signed_i  = s;
    bus.start_i   = 1'b1;
    exp_q.push_back(model(a, b, s));
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.ready_o) begin
        lat = k;
        break;
      end
      check("stall_busy", 64'(bus.stall_o), 64'(1));
      if (k == 3) begin
        // Operand and mode changes mid-division must be ignored.
        bus.opdata1_i = $urandom;
        bus.opdata2_i = $urandom;
        bus.signed_i  = ~s;
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=none required=%0d", exp_latency(b));
    end else begin
      check("latency", 64'(lat), 64'(exp_latency(b)));
      check("stall_done", 64'(bus.stall_o), 64'(0));
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("ready_hold", 64'(bus.ready_o), 64'(1));
    end
    @(posedge clk); #1;
    bus.start_i = 1'b0;
  endtask

  // Global bound so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           s;
    int           sel;

    bus.start_i   = 1'b0;
    bus.signed_i  = 1'b0;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
    bus.annul_i   = 1'b0;

    // Reset values.
    #12;
    check("rst_result", bus.result_o, 64'(0));
    check("rst_ready",  64'(bus.ready_o), 64'(0));
    check("rst_stall",  64'(bus.stall_o), 64'(0));
    @(negedge clk);
    resetn = 1'b1;

    // Directed cases.
    run_div(32'd100, 32'd7, 1'b0, 2);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    run_div(32'd5, 32'd0, 1'b0, 1);
    run_div(32'hFFFF_FFFB, 32'd0, 1'b1, 0);
    run_div(32'd20, 32'd3, 1'b0, 0);
    run_div(32'd20, 32'd6, 1'b0, 0);

    // Simultaneous start and annul in IDLE: never accepted.
    @(posedge clk); #1;
    bus.opdata1_i = 32'd50;
    bus.opdata2_i = 32'd5;
    bus.start_i   = 1'b1;
    bus.annul_i   = 1'b1;
    @(negedge clk);
    check("start_annul_stall", 64'(bus.stall_o), 64'(0));
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    @(negedge clk);
    check("start_annul_notacc", 64'(bus.stall_o), 64'(0));

    // Flush in the middle of a division.
    @(posedge clk); #1;
    bus.opdata1_i = 32'd1000;
    bus.opdata2_i = 32'd3;
    bus.signed_i  = 1'b0;
    bus.start_i   = 1'b1;
    repeat (11) @(negedge clk);
    @(posedge clk); #1;
    bus.annul_i = 1'b1;
    @(negedge clk);
    check("annul_stall", 64'(bus.stall_o), 64'(0));
    check("annul_ready", 64'(bus.ready_o), 64'(0));
    @(posedge clk); #1;
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    @(negedge clk);
    check("annul_idle_stall", 64'(bus.stall_o), 64'(0));
    repeat (40) @(negedge clk);
    run_div(32'd9, 32'd3, 1'b0, 0);

    // Asynchronous reset during BUSY.
    @(posedge clk); #1;
    bus.opdata1_i = 32'd77;
    bus.opdata2_i = 32'd4;
    bus.start_i   = 1'b1;
    repeat (6) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_result", bus.result_o, 64'(0));
    check("arst_ready",  64'(bus.ready_o), 64'(0));
    check("arst_stall",  64'(bus.stall_o), 64'(0));
    bus.start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    run_div(32'd8, 32'd8, 1'b0, 0);

    // Randomised traffic.
    for (int n = 0; n < 24; n++) begin
      a   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0)      b = '0;
      else if (sel < 4)  b = W'($urandom_range(1, 20));
      else               b = $urandom;
      s = bit'($urandom_range(0, 1));
      if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
      run_div(a, b, s, $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    check("queue_drain", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Iterative divider controller for the MIPS EX stage. It accepts DIV/DIVU requests, runs a 32-step restoring division, and holds the pipeline stalled while the division runs. It delivers {HI=remainder, LO=quotient} to the HI/LO write path and honours exception flushes mid-operation.

## Interface
- WIDTH, 32, operand width; the iteration count equals WIDTH.
- clk  in  1  pipeline clock.
- resetn  in  1  asynchronous, active-low reset.
- start_i  in  1  DIV/DIVU in EX; held high while EX is stalled.
- signed_i  in  1  1 selects DIV, 0 selects DIVU; sampled with the operands.
- opdata1_i  in  WIDTH  dividend.
- opdata2_i  in  WIDTH  divisor.
- annul_i  in  1  exception flush; cancels any pending or running division.
- result_o  out  2*WIDTH  {remainder, quotient}; valid while ready_o is high.
- ready_o  out  1  result valid.
- stall_o  out  1  stall request to the hazard unit.

## Operation
- FSM states: IDLE, BUSY, DONE. Encoding lives in the package.
- IDLE:
  - On start_i & !annul_i, latch operands and signed_i.
  - When signed_i = 1, latch the magnitudes |op1| and |op2|, and record neg_q = sign1 ^ sign2 and neg_r = sign1.
  - Clear the step counter and go to BUSY.
- BUSY: each cycle performs one restoring step on the partial-remainder/quotient register and increments the counter. After step WIDTH, go to DONE.
- DONE:
  - Final results are registered on entry.
  - Quotient is negated when neg_q; remainder is negated when neg_r.
  - ready_o = 1 and result_o is stable.
  - Stay in DONE while start_i = 1. Return to IDLE on the first cycle start_i = 0.
- Divide by zero (opdata2_i == 0): result_o = {opdata1_i as latched (raw, no sign fix), {WIDTH{1'b1}}} for both signedness modes. No exception is raised.
- annul_i in any state: next state is IDLE; ready_o and stall_o go low the same cycle; result_o is undefined.
- stall_o = (IDLE & start_i & !annul_i) | (BUSY & !annul_i). It is low in DONE, so EX advances in the ready cycle.
- While in BUSY, a start_i change is ignored, and operand changes are ignored.

## Timing
- Reset values: state = IDLE, ready_o = 0, stall_o = 0, result_o = 0, counter = 0.
- Normal latency: request accepted in cycle N, BUSY for cycles N+1..N+WIDTH, ready_o first high in cycle N+WIDTH+1 (33 cycles for WIDTH = 32).
- ready_o stays high every cycle that start_i remains high in DONE.
- A new request is accepted only from IDLE, so a back-to-back DIV has one dead cycle after start_i drops.
- Simultaneous start_i and annul_i in IDLE: the request is not accepted and stall_o = 0.
- resetn asserted mid-BUSY: state returns to IDLE immediately (asynchronous) and all outputs take their reset values.

## Configuration
- DIV_ZERO_FAST_EN defined:
  - A zero divisor detected in IDLE goes directly to DONE.
  - ready_o is high in cycle N+1.
- Not defined: a zero divisor runs all WIDTH steps.
- Result values are identical in both cases; only latency differs.

## Structure
- The shared package holds:
  - state encoding constants (IDLE/BUSY/DONE);
  - DIV_WIDTH = 32;
  - the counter width, $clog2(DIV_WIDTH+1).
- Sub-module div_step: purely combinational single restoring iteration.
  - Inputs: partial remainder, shifted dividend bit, divisor.
  - Outputs: next remainder, quotient bit.
- div_ctrl owns the FSM, the counter, the sign fix-up and the operand/result registers.

## Test plan
- DIVU 100 / 7, start held high → ready_o in cycle N+33; result_o = {32'd2, 32'd14}; stall_o high for cycles N..N+32.
- DIV −7 / 2 (0xFFFFFFF9 / 2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- DIVU 5 / 0 → result_o = {32'd5, 32'hFFFFFFFF}. Latency is 1 cycle with DIV_ZERO_FAST_EN and 33 cycles without it.
- annul_i pulsed at BUSY step 10 → IDLE next cycle; stall_o low in the annul cycle; ready_o never asserted. A following DIVU 9 / 3 returns {0, 3}.
- Back-to-back DIVU 20/3 then DIVU 20/6 with start_i dropped for 1 cycle between them → {2, 6}, then {2, 3}. The second request is accepted only from IDLE.
- resetn asserted at BUSY step 5 → all outputs 0 asynchronously. After release, DIVU 8/8 → {0, 1} in 33 cycles.
